// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_seq_pkg;

  localparam int REG_SIZE          = 32;
  localparam int VEC_SIZE          = 4;
  localparam int STATE_W           = REG_SIZE * VEC_SIZE;
  localparam int NUM_ROUNDS_AES128 = 10;
  localparam int ROUND_W           = 4;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS_AES128);

  // Operation select presented to the shared round-unit mux.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_SUB   = 3'd1,
    OP_SHIFT = 3'd2,
    OP_MIX   = 3'd3,
    OP_ARK   = 3'd4
  } op_e;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARK0  = 3'd1,
    SUB   = 3'd2,
    SHIFT = 3'd3,
    MIX   = 3'd4,
    ARK   = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_ctr.sv
// Round counter: synchronous clear, increment, saturates at the last AES
// round and never wraps. is_last_o flags the final (MIX-less) round.
module aes_round_ctr
  import aes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               is_last_o
);

  logic [ROUND_W-1:0] round_q, round_d;

  // Next count: clear wins over increment; increment stops at the last round.
  always_comb begin
    round_d = round_q;
    if (clr_i) begin
      round_d = '0;
    end else if (inc_i && (round_q != LAST_ROUND)) begin
      round_d = round_q + ROUND_W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o   = round_q;
  assign is_last_o = (round_q == LAST_ROUND);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps one 4x32 state through the external shared
// round units (sub_bytes, shift_rows, mix_columns, add_round_key), one op per
// cycle, capturing the combinational op_result back into the state register.
// Optional feature macro: AES_SEQ_ABORT_EN adds an 'abort' input that drops a
// running sequence back to IDLE with a cleared state register.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. start_ready is high only in IDLE; out_valid is high only in
// DONE and data_out holds steady until out_ready is seen. Neither valid waits
// on its ready.
module aes_round_sequencer
  import aes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
`ifdef AES_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [STATE_W-1:0] data_in,
  output logic [2:0]         op_sel,
  output logic [STATE_W-1:0] op_vect,
  input  logic [STATE_W-1:0] op_result,
  output logic [ROUND_W-1:0] rk_idx,
  output logic               busy,
  output logic [ROUND_W-1:0] round_num,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out,
  output logic [2:0]         fsm_state
);

  seq_state_e         state_q, state_d;
  logic [STATE_W-1:0] vec_q, vec_d;
  logic               accept;
  logic               ctr_inc;
  logic               is_last;
  logic               abort_w;
  logic [ROUND_W-1:0] round;

`ifdef AES_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_round_ctr u_round_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .inc_i     (ctr_inc),
    .round_o   (round),
    .is_last_o (is_last)
  );

  // FSM next state, state-register next value and all control outputs.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    op_sel      = OP_NONE;
    rk_idx      = '0;
    start_ready = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    accept      = 1'b0;
    ctr_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        busy        = 1'b0;
        start_ready = 1'b1;
        if (start_valid) begin
          accept  = 1'b1;
          vec_d   = data_in;
          state_d = ARK0;
        end
      end
      ARK0: begin
        op_sel  = OP_ARK;
        rk_idx  = round;
        vec_d   = op_result;
        ctr_inc = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        op_sel  = OP_SUB;
        vec_d   = op_result;
        state_d = SHIFT;
      end
      SHIFT: begin
        op_sel  = OP_SHIFT;
        vec_d   = op_result;
        // The final round has no MixColumns step.
        state_d = is_last ? ARK : MIX;
      end
      MIX: begin
        op_sel  = OP_MIX;
        vec_d   = op_result;
        state_d = ARK;
      end
      ARK: begin
        op_sel  = OP_ARK;
        rk_idx  = round;
        vec_d   = op_result;
        ctr_inc = 1'b1;
        state_d = is_last ? DONE : SUB;
      end
      DONE: begin
        busy      = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
    // Abort discards the partial state; the round counter is left untouched.
    if (busy && abort_w) begin
      state_d = IDLE;
      vec_d   = '0;
      ctr_inc = 1'b0;
    end
  end

  // FSM and state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  assign op_vect   = vec_q;
  assign data_out  = vec_q;
  assign round_num = round;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer. Provides behavioural AES round units and
// a FIPS-197 key schedule behind op_sel, and checks results against a
// full-block AES-128 reference model.
module tb_aes_round_sequencer;
  import aes_seq_pkg::*;

  localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PT1 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start_valid, start_ready, busy, out_valid, out_ready, abort;
  logic [127:0] data_in, op_vect, op_result, data_out;
  logic [2:0]   op_sel, fsm_state;
  logic [3:0]   rk_idx, round_num;

  aes_round_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .data_in     (data_in),
    .op_sel      (op_sel),
    .op_vect     (op_vect),
    .op_result   (op_result),
    .rk_idx      (rk_idx),
    .busy        (busy),
    .round_num   (round_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .fsm_state   (fsm_state)
  );

  // ---------------- AES helpers ----------------
  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk     [0:10];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the definition: multiplicative inverse (a^254) then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_t[s[8*i +: 8]];
    return o;
  endfunction

  // Byte (row r, column c) sits at bit 127-8*(4c+r); row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  // Whole-block reference encryption.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NUM_ROUNDS_AES128; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < NUM_ROUNDS_AES128) s = mix_columns(s);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic build_tables();
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Shared round units behind op_sel.
  always_comb begin
    case (op_sel)
      OP_SUB:   op_result = sub_bytes(op_vect);
      OP_SHIFT: op_result = shift_rows(op_vect);
      OP_MIX:   op_result = mix_columns(op_vect);
      OP_ARK:   op_result = op_vect ^ rk[rk_idx];
      default:  op_result = op_vect;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  logic [2:0]   op_log[$];
  logic [3:0]   rk_log[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] pt);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready_before_send", start_ready, 1);
    start_valid = 1'b1;
    data_in     = pt;
    @(negedge clk);
    start_valid = 1'b0;
    exp_q.push_back(aes_ref(pt));
  endtask

  // Called at the negedge right after the accept edge (cycle 1). Logs the
  // op trace, optionally pulses start_valid mid-run, returns the latency.
  task automatic wait_done(input int pulse_cyc, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (op_sel != 3'(OP_NONE)) op_log.push_back(op_sel);
      if (op_sel == 3'(OP_ARK)) rk_log.push_back(rk_idx);
      if (lat == pulse_cyc) begin
        chk("start_ready_while_busy", start_ready, 0);
        data_in     = {$urandom, $urandom, $urandom, $urandom};
        start_valid = 1'b1;
      end
      @(negedge clk);
      start_valid = 1'b0;
      lat++;
    end
  endtask

  task automatic consume(input int hold, input bit with_start);
    logic [127:0] e;
    chk("sb_depth", 128'(exp_q.size()), 128'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_data_out", data_out, e);
      chk("bp_start_ready", start_ready, 0);
      @(negedge clk);
    end
    chk("ciphertext", data_out, e);
    chk("done_round_num", round_num, 10);
    out_ready = 1'b1;
    if (with_start) begin
      start_valid = 1'b1;
      data_in     = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    out_ready   = 1'b0;
    start_valid = 1'b0;
    chk("idle_start_ready", start_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("no_accept_round_num", round_num, 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_op_sel"}, op_sel, 3'(OP_NONE));
    chk({tag, "_rk_idx"}, rk_idx, 0);
    chk({tag, "_round_num"}, round_num, 0);
    chk({tag, "_data_out"}, data_out, 0);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (round_num != r && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_round", round_num, r);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] exp_ops[$];
    logic [3:0] exp_rk[$];
    logic [127:0] pt;
    int mix_last;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    out_ready   = 1'b0;
    abort       = 1'b0;
    data_in     = '0;
    build_tables();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vector, latency and op trace.
    chk("model_fips", aes_ref(PT1), CT1);
    exp_ops.push_back(3'(OP_ARK));
    exp_rk.push_back(4'd0);
    for (int r = 1; r <= NUM_ROUNDS_AES128; r++) begin
      exp_ops.push_back(3'(OP_SUB));
      exp_ops.push_back(3'(OP_SHIFT));
      if (r < NUM_ROUNDS_AES128) exp_ops.push_back(3'(OP_MIX));
      exp_ops.push_back(3'(OP_ARK));
      exp_rk.push_back(4'(r));
    end
    op_log.delete();
    rk_log.delete();
    send(PT1);
    wait_done(0, cyc);
    chk("fips_latency", 128'(cyc), 128'd41);
    chk("fips_ciphertext", data_out, CT1);
    chk("op_trace_len", 128'(op_log.size()), 128'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++)
      chk($sformatf("op_trace_%0d", i), op_log[i], exp_ops[i]);
    chk("rk_trace_len", 128'(rk_log.size()), 128'(exp_rk.size()));
    for (int i = 0; i < exp_rk.size() && i < rk_log.size(); i++)
      chk($sformatf("rk_trace_%0d", i), rk_log[i], exp_rk[i]);
    mix_last = 0;
    for (int i = 4 * (NUM_ROUNDS_AES128 - 1) + 1; i < op_log.size(); i++)
      if (op_log[i] == 3'(OP_MIX)) mix_last++;
    chk("no_mix_last_round", 128'(mix_last), 128'd0);
    consume(0, 1'b0);

    // Backpressure in DONE, then out_ready together with start_valid.
    send(PT1);
    wait_done(0, cyc);
    consume(5, 1'b1);

    // start_valid pulsed while busy is ignored.
    send(PT1);
    wait_done(10, cyc);
    chk("busy_start_latency", 128'(cyc), 128'd41);
    chk("busy_start_ciphertext", data_out, CT1);
    consume(0, 1'b0);

    // Reset mid-run returns to reset values at once; rerun afterwards.
    send(PT1);
    wait_round(4'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(PT1);
    wait_done(0, cyc);
    chk("rerun_latency", 128'(cyc), 128'd41);
    chk("rerun_ciphertext", data_out, CT1);
    consume(0, 1'b0);

`ifdef AES_SEQ_ABORT_EN
    // Abort at round 3: back to IDLE next cycle, no result ever offered.
    begin
      bit seen_valid;
      send(PT1);
      wait_round(4'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_start_ready", start_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_data_out", data_out, 0);
      seen_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (out_valid) seen_valid = 1'b1;
        @(negedge clk);
      end
      chk("abort_no_out_valid", seen_valid, 0);
      exp_q.delete();
    end
`endif

    // Random plaintexts with random consumer stalls.
    for (int k = 0; k < 4; k++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(pt);
      wait_done(0, cyc);
      chk("rand_latency", 128'(cyc), 128'd41);
      consume($urandom_range(0, 3), 1'(k % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
